// File: rtl/program_sequencer.sv
// program_sequencer: program-counter controller with a hardware return stack.
// Picks the next program-memory address each cycle from the decoded jump,
// call and return controls, the zero flag and the memory-wait hold.
module program_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sync_reset,
  input  logic       jmp,
  input  logic       jmp_nz,
  input  logic       dont_jmp,
  input  logic       call,
  input  logic       ret,
  input  logic [3:0] ir_nibble,
  input  logic       hold,
  output logic [7:0] pm_addr,
  output logic [7:0] pc,
  output logic [3:0] sp,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       overflow,
  output logic       underflow
);

  localparam int         IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [3:0] DEPTH_VAL = 4'(STACK_DEPTH);

  logic [7:0]             pc_reg;
  logic [3:0]             sp_reg;
  logic                   overflow_reg;
  logic                   underflow_reg;
  logic [7:0]             stack_reg [STACK_DEPTH];

  logic [7:0]             pc_inc;
  logic [7:0]             target;
  logic [7:0]             stack_top;
  logic [IDX_W-1:0]       top_idx;
  logic                   full_w;
  logic                   empty_w;

  logic [7:0]             pm_addr_next;
  logic [3:0]             sp_next;
  logic                   overflow_next;
  logic                   underflow_next;
  logic                   push_en;
  logic [STACK_DEPTH-1:0] push_sel;

  // Page-relative target and modulo-256 increment; 8-bit add wraps FF to 00.
  assign pc_inc    = pc_reg + 8'd1;
  assign target    = {pc_reg[7:4], ir_nibble};
  assign full_w    = (sp_reg == DEPTH_VAL);
  assign empty_w   = (sp_reg == 4'd0);
  // Top of stack is entry[sp-1]; only consumed when the stack is non-empty.
  assign top_idx   = IDX_W'(sp_reg - 4'd1);
  assign stack_top = stack_reg[top_idx];

  // Per-entry write strobes: a push lands in the slot addressed by sp.
  for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_push_sel
    assign push_sel[gi] = push_en && (sp_reg == 4'(gi));
  end

  // Strict-priority next-address selection and stack/flag next state.
  always_comb begin
    pm_addr_next   = pc_inc;
    sp_next        = sp_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    push_en        = 1'b0;
    if (sync_reset) begin
      pm_addr_next   = 8'h00;
      sp_next        = 4'd0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else if (hold) begin
      pm_addr_next = pc_reg;
    end else if (ret) begin
      if (empty_w) begin
        underflow_next = 1'b1;
      end else begin
        pm_addr_next = stack_top;
        sp_next      = sp_reg - 4'd1;
      end
    end else if (call) begin
      // A call on a full stack still jumps; only the push is dropped.
      pm_addr_next = target;
      if (full_w) begin
        overflow_next = 1'b1;
      end else begin
        push_en = 1'b1;
        sp_next = sp_reg + 4'd1;
      end
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      pm_addr_next = target;
    end
  end

  // PC, stack pointer and sticky flags all advance on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg        <= 8'h00;
      sp_reg        <= 4'd0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      pc_reg        <= pm_addr_next;
      sp_reg        <= sp_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Return-stack storage: written only by a successful push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_reg[i] <= 8'h00;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push_sel[i]) stack_reg[i] <= pc_inc;
      end
    end
  end

  assign pm_addr     = pm_addr_next;
  assign pc          = pc_reg;
  assign sp          = sp_reg;
  assign stack_full  = full_w;
  assign stack_empty = empty_w;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: directed vector table, hold and reset
// sequences, and randomized control traffic against a queue-based model.
module tb_program_sequencer;

  localparam int DEPTH = 4;

  // Control word bit positions: {sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_SR   = 7'b1000000;
  localparam logic [6:0] C_HOLD = 7'b0100000;
  localparam logic [6:0] C_JMP  = 7'b0010000;
  localparam logic [6:0] C_JNZ  = 7'b0001000;
  localparam logic [6:0] C_DJ   = 7'b0000100;
  localparam logic [6:0] C_CALL = 7'b0000010;
  localparam logic [6:0] C_RET  = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sync_reset = 1'b0;
  logic       jmp = 1'b0;
  logic       jmp_nz = 1'b0;
  logic       dont_jmp = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [3:0] ir_nibble = 4'h0;
  logic       hold = 1'b0;
  logic [7:0] pm_addr;
  logic [7:0] pc;
  logic [3:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       overflow;
  logic       underflow;

  program_sequencer #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp),
    .call(call), .ret(ret), .ir_nibble(ir_nibble), .hold(hold),
    .pm_addr(pm_addr), .pc(pc), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: PC value, return stack as a queue, sticky flags.
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] last_pm;

  typedef struct {
    logic       run_en;
    logic [7:0] run_pc;
    logic [6:0] ctrl;
    logic [3:0] nib;
    logic [7:0] e_pm;
    logic [7:0] e_pc;
    logic [3:0] e_sp;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic run_en, input logic [7:0] run_pc,
                              input logic [6:0] ctrl, input logic [3:0] nib,
                              input logic [7:0] e_pm, input logic [7:0] e_pc,
                              input logic [3:0] e_sp, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.run_en = run_en; v.run_pc = run_pc; v.ctrl = ctrl; v.nib = nib;
    v.e_pm = e_pm; v.e_pc = e_pc; v.e_sp = e_sp; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Applies one cycle of controls to the model; returns the address fetched.
  function automatic logic [7:0] model_step(input logic [6:0] c, input logic [3:0] nib);
    logic [7:0] nxt;
    logic [7:0] tgt;
    nxt = m_pc + 8'd1;
    tgt = {m_pc[7:4], nib};
    if (c[6]) begin
      nxt = 8'h00;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (c[5]) begin
      nxt = m_pc;
    end else if (c[0]) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else nxt = m_stk.pop_back();
    end else if (c[1]) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else m_stk.push_back(m_pc + 8'd1);
      nxt = tgt;
    end else if (c[4] || (c[3] && !c[2])) begin
      nxt = tgt;
    end
    m_pc = nxt;
    return nxt;
  endfunction

  // One clock: drive at posedge+1, check pm_addr at negedge, state after edge.
  task automatic step(input logic [6:0] c, input logic [3:0] nib);
    logic [7:0] exp_pm;
    {sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret} = c;
    ir_nibble = nib;
    exp_pm = model_step(c, nib);
    @(negedge clk);
    last_pm = pm_addr;
    chk("pm_addr", pm_addr, exp_pm);
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("sp", sp, m_stk.size());
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("stack_full", stack_full, m_stk.size() == DEPTH);
    chk("stack_empty", stack_empty, m_stk.size() == 0);
    $display("[TB] ctrl=%b nib=%h pm_addr=%h pc=%h sp=%0d ovf=%b unf=%b",
             c, nib, last_pm, pc, sp, overflow, underflow);
  endtask

  // Sequential fetch until the PC reaches a given address (bounded).
  task automatic run_to(input logic [7:0] t);
    int n = 0;
    while (m_pc != t && n < 300) begin
      step(C_NONE, 4'h0);
      n++;
    end
    chk("run_to", pc, t);
  endtask

  task automatic random_steps(input int count);
    logic [6:0] c;
    for (int i = 0; i < count; i++) begin
      c = C_NONE;
      if ($urandom_range(0, 99) < 2)  c = c | C_SR;
      if ($urandom_range(0, 99) < 15) c = c | C_HOLD;
      if ($urandom_range(0, 99) < 20) c = c | C_RET;
      if ($urandom_range(0, 99) < 25) c = c | C_CALL;
      if ($urandom_range(0, 99) < 10) c = c | C_JMP;
      if ($urandom_range(0, 99) < 15) c = c | C_JNZ;
      if ($urandom_range(0, 1) == 1)  c = c | C_DJ;
      step(c, 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    // Directed scenario, applied from the reset state.
    vecs.push_back(mk(0, 8'h00, C_NONE,        4'h0, 8'h01, 8'h01, 4'd0, 0, 0));
    vecs.push_back(mk(0, 8'h00, C_NONE,        4'h0, 8'h02, 8'h02, 4'd0, 0, 0));
    vecs.push_back(mk(0, 8'h00, C_NONE,        4'h0, 8'h03, 8'h03, 4'd0, 0, 0));
    vecs.push_back(mk(1, 8'h37, C_JMP,         4'hA, 8'h3A, 8'h3A, 4'd0, 0, 0));
    vecs.push_back(mk(0, 8'h00, C_JNZ | C_DJ,  4'hA, 8'h3B, 8'h3B, 4'd0, 0, 0));
    vecs.push_back(mk(0, 8'h00, C_JNZ,         4'hA, 8'h3A, 8'h3A, 4'd0, 0, 0));
    vecs.push_back(mk(1, 8'hFF, C_NONE,        4'h0, 8'h00, 8'h00, 4'd0, 0, 0));
    vecs.push_back(mk(1, 8'h10, C_CALL,        4'hF, 8'h1F, 8'h1F, 4'd1, 0, 0));
    vecs.push_back(mk(1, 8'h22, C_CALL,        4'hF, 8'h2F, 8'h2F, 4'd2, 0, 0));
    vecs.push_back(mk(1, 8'h35, C_CALL,        4'hF, 8'h3F, 8'h3F, 4'd3, 0, 0));
    vecs.push_back(mk(1, 8'h47, C_CALL,        4'h0, 8'h40, 8'h40, 4'd4, 0, 0));
    vecs.push_back(mk(1, 8'h50, C_CALL,        4'h2, 8'h52, 8'h52, 4'd4, 1, 0));
    vecs.push_back(mk(0, 8'h00, C_RET,         4'h0, 8'h48, 8'h48, 4'd3, 1, 0));
    vecs.push_back(mk(0, 8'h00, C_RET,         4'h0, 8'h36, 8'h36, 4'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, C_RET,         4'h0, 8'h23, 8'h23, 4'd1, 1, 0));
    vecs.push_back(mk(0, 8'h00, C_RET,         4'h0, 8'h11, 8'h11, 4'd0, 1, 0));
    vecs.push_back(mk(1, 8'h60, C_RET,         4'h0, 8'h61, 8'h61, 4'd0, 1, 1));
    vecs.push_back(mk(0, 8'h00, C_SR,          4'h0, 8'h00, 8'h00, 4'd0, 0, 0));
    vecs.push_back(mk(1, 8'h23, C_CALL,        4'h0, 8'h20, 8'h20, 4'd1, 0, 0));
    vecs.push_back(mk(0, 8'h00, C_CALL | C_RET, 4'h0, 8'h24, 8'h24, 4'd0, 0, 0));

    // Asynchronous reset asserted mid-cycle, well before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 8'h00);
    chk("async_rst_sp", sp, 4'd0);
    chk("async_rst_empty", stack_empty, 1'b1);
    chk("async_rst_pm", pm_addr, 8'h01);
    @(posedge clk);
    #1;
    chk("rst_hold_pc", pc, 8'h00);
    reset_n = 1'b1;
    model_reset();

    foreach (vecs[i]) begin
      if (vecs[i].run_en) run_to(vecs[i].run_pc);
      step(vecs[i].ctrl, vecs[i].nib);
      chk($sformatf("vec%0d_pm", i), last_pm, vecs[i].e_pm);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_sp", i), sp, vecs[i].e_sp);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].e_ovf);
      chk($sformatf("vec%0d_unf", i), underflow, vecs[i].e_unf);
    end

    // Hold for three cycles with a jump pending, then the jump is taken.
    for (int i = 0; i < 3; i++) begin
      step(C_HOLD | C_JMP, 4'h9);
      chk("hold_pm", last_pm, 8'h24);
      chk("hold_pc", pc, 8'h24);
    end
    step(C_JMP, 4'h9);
    chk("hold_release_pm", last_pm, 8'h29);
    chk("hold_release_pc", pc, 8'h29);
    step(C_RET, 4'h0);
    chk("empty_ret_pm", last_pm, 8'h2A);
    chk("empty_ret_unf", underflow, 1'b1);
    step(C_CALL, 4'h0);
    chk("pre_sr_sp", sp, 4'd1);
    // sync_reset wins over hold.
    step(C_SR | C_HOLD | C_CALL, 4'h0);
    chk("sr_hold_pm", last_pm, 8'h00);
    chk("sr_hold_pc", pc, 8'h00);
    chk("sr_hold_sp", sp, 4'd0);
    chk("sr_hold_unf", underflow, 1'b0);

    random_steps(1500);

    // Asynchronous reset in the middle of random traffic.
    {sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret} = C_NONE;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 8'h00);
    chk("mid_rst_sp", sp, 4'd0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_unf", underflow, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    random_steps(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
